// File: rtl/cpu_ifetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready memory
// handshake and hands them to decode/execute over a valid/ack handshake.
module cpu_ifetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] PC_plus_4,
  input  logic [31:0] Addr_Result,
  input  logic        Zero,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic [31:0] Read_data_1,
  output logic        fetch_err
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] cnt_r;
  logic        err_r;
  logic [31:0] next_pc_s;
  logic        taken_s;
  logic        timeout_hit_s;

  assign PC_plus_4   = pc_r + 32'd4;
  assign pc          = pc_r;
  assign imem_addr   = pc_r;
  assign instruction = instr_r;
  assign fetch_err   = err_r;
  // Gated by rst_n so both handshakes drop the instant reset asserts.
  assign imem_req    = rst_n & (state_r == ST_REQ);
  assign instr_valid = rst_n & (state_r == ST_VALID);

  assign taken_s       = (Branch & Zero) | (nBranch & ~Zero);
  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == TIMEOUT_LAST);

  // Next-PC selection: jr, then j/jal, then taken branch, else sequential.
  always_comb begin
    next_pc_s = PC_plus_4;
    if (Jr) begin
      next_pc_s = {Read_data_1[31:2], 2'b00};
    end else if (Jmp || Jal) begin
      next_pc_s = {PC_plus_4[31:28], instr_r[25:0], 2'b00};
    end else if (taken_s) begin
      next_pc_s = Addr_Result;
    end else begin
      next_pc_s = PC_plus_4;
    end
  end

  // Fetch FSM with PC, instruction latch, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_REQ;
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
      cnt_r   <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_REQ: begin
          // A ready on the final allowed cycle still wins over the timeout.
          if (imem_ready) begin
            instr_r <= imem_rdata;
            cnt_r   <= 32'd0;
            state_r <= ST_VALID;
          end else if (timeout_hit_s) begin
            cnt_r   <= cnt_r + 32'd1;
            err_r   <= 1'b1;
            state_r <= ST_ERR;
          end else begin
            cnt_r   <= cnt_r + 32'd1;
          end
        end
        ST_VALID: begin
          if (instr_ack) begin
            pc_r    <= next_pc_s;
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_VALID;
          end
        end
        ST_ERR: begin
          err_r   <= 1'b1;
          state_r <= ST_ERR;
        end
        default: begin
          err_r   <= 1'b1;
          state_r <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
Instruction-fetch stage sitting directly upstream of the executor. It holds the PC and fetches instruction words from a variable-latency instruction memory using a req/ready handshake. It presents one instruction at a time to decode/execute with a valid/ack handshake. On ack it selects the next PC from the executor's branch target, Zero flag, jump fields or the jr register value.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
TIMEOUT_CYCLES, 16, consecutive unanswered request cycles before fetch error; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; asserted throughout the REQ state
imem_addr  output  32  fetch address; always equal to pc
imem_ready  input  1  memory has imem_rdata valid this cycle; ignored when imem_req=0
imem_rdata  input  32  fetched instruction word
instruction  output  32  held instruction word
instr_valid  output  1  instruction is valid and awaiting ack
instr_ack  input  1  consumer has executed the instruction; control inputs are valid this cycle
pc  output  32  address of the current/held instruction
PC_plus_4  output  32  pc+4, combinational, modulo 2^32
Addr_Result  input  32  branch target from executor
Zero  input  1  executor zero flag
Branch  input  1  beq
nBranch  input  1  bne
Jmp  input  1  j
Jal  input  1  jal
Jr  input  1  jr
Read_data_1  input  32  rs value for jr
fetch_err  output  1  sticky fetch-timeout error flag

Behaviour:
- Decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-fetch): pc=RESET_PC, state=REQ, instruction=0, timeout counter=0, fetch_err=0. While rst_n=0, imem_req=0 and instr_valid=0.
- States:
  - REQ: imem_req=1, instr_valid=0.
  - VALID: imem_req=0, instr_valid=1.
  - ERR: imem_req=0, instr_valid=0, fetch_err=1.
- REQ state:
  - If imem_ready=1 at the clock edge: instruction<=imem_rdata, counter<=0, go to VALID.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES!=0 and the TIMEOUT_CYCLES-th consecutive request cycle ends with ready=0: go to ERR.
  - Ready arriving on that same final cycle wins: go to VALID, no error.
- Latency: minimum 1 cycle from imem_req to instr_valid; 2 cycles from ack to the next instr_valid when memory answers immediately.
- VALID state:
  - instruction and pc hold stable until instr_ack=1.
  - On ack: pc<=next_pc, go to REQ.
  - instr_ack is ignored outside VALID.
  - Control inputs are sampled only at an ack edge.
- next_pc priority:
  1. Jr: {Read_data_1[31:2],2'b00}.
  2. Jmp or Jal: {PC_plus_4[31:28], instruction[25:0], 2'b00}.
  3. Branch taken: (Branch & Zero) | (nBranch & ~Zero) → Addr_Result.
  4. Otherwise PC_plus_4.
- Simultaneous control inputs resolve by this priority only, with no error. Branch and nBranch both high counts as taken if either condition holds.
- Arithmetic: all PC math is 32-bit unsigned and wraps (pc=32'hFFFF_FFFC gives PC_plus_4=0).
- ERR state: persists until reset. fetch_err drives 1 from the cycle after entry.
- imem_addr never changes while imem_req=1.

Test Plan:
- Reset, then memory ready on the first request with rdata=32'h2008_0005 → imem_addr=0; next cycle instr_valid=1, instruction=32'h2008_0005; ack with no controls → pc=4.
- Memory ready delayed 3 cycles → imem_req and imem_addr stable for 3 cycles; instr_valid rises in cycle 4; no fetch_err.
- At pc=8, Branch=1, Zero=1, Addr_Result=32'h40 on ack → next imem_addr=32'h40. Repeat with Zero=0 → 32'hC.
- At pc=32'h1000_0010, instruction=32'h0C00_0100, Jal=1 → 32'h1000_0400. Jr=1 with Jal=1, Read_data_1=32'h123 → 32'h120 (Jr wins, low bits cleared).
- Ready held low for 16 cycles → fetch_err=1, imem_req=0, state held. Then rst_n=0 mid-error → fetch_err=0, pc=RESET_PC, fetching resumes after release.
- Assert rst_n=0 during REQ with ready pending → outputs clear immediately (asynchronous); a late ready during reset is ignored.
